// File: rtl/iob_split_if.sv
// Native valid/ready bus bundle for the 1-to-N request splitter.
//   m_req  : master request  {valid, addr, wdata, wstrb}, valid at MSB
//   m_resp : master response {rdata, ready}, ready at LSB
//   s_req  : per-slave requests, slot k at [(k+1)*REQ_W-1 : k*REQ_W]
//   s_resp : per-slave responses, same slot packing
// Modport master: environment side (drives m_req and slave responses).
// Modport slave : splitter side (consumes m_req, drives s_req/m_resp).
interface iob_split_if #(
  parameter int unsigned N_SLAVES = 2,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32
);
  localparam int unsigned REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8;
  localparam int unsigned RESP_W = DATA_W + 1;

  logic [REQ_W-1:0]           m_req;
  logic [RESP_W-1:0]          m_resp;
  logic [N_SLAVES*REQ_W-1:0]  s_req;
  logic [N_SLAVES*RESP_W-1:0] s_resp;

  modport master (
    output m_req,
    input  m_resp,
    input  s_req,
    output s_resp
  );

  modport slave (
    input  m_req,
    output m_resp,
    output s_req,
    input  s_resp
  );
endinterface

// File: rtl/iob_split.sv
// Single-master to N-slave splitter for the native valid/ready memory bus.
// Decodes a slave-select field from the request address, routes the request
// to that slave with zero added latency and returns its response. Selects
// beyond the last slave are answered locally with a one-cycle error ready.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset; all bus outputs are 0 while low
//   bus_io : iob_split_if.slave (m_req in, m_resp out, s_req out, s_resp in)
module iob_split #(
  parameter int unsigned N_SLAVES = 2,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned P_SLAVES = ADDR_W - 1
) (
  input logic        clk,
  input logic        rst_n,
  iob_split_if.slave bus_io
);

  localparam int unsigned NB      = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned REQ_W   = 1 + ADDR_W + DATA_W + STRB_W;
  localparam int unsigned RESP_W  = DATA_W + 1;
  // Bit position of the select-field MSB inside the packed request.
  localparam int unsigned SEL_MSB = DATA_W + STRB_W + P_SLAVES;
  localparam logic [NB:0] N_SLAVES_V = (NB + 1)'(N_SLAVES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [NB-1:0]     sel_q, sel_d;

  logic              m_valid_c;
  logic [NB-1:0]     addr_sel_c;
  logic              in_range_c;
  logic [NB-1:0]     cur_sel_c;
  logic [RESP_W-1:0] sel_resp_c;
  logic              route_en_c;
  logic [RESP_W-1:0] m_resp_c;

  // Address decode; a single slave always decodes to slot 0.
  assign m_valid_c  = bus_io.m_req[REQ_W-1];
  assign addr_sel_c = (N_SLAVES == 1) ? '0 : bus_io.m_req[SEL_MSB -: NB];
  assign in_range_c = ({1'b0, addr_sel_c} < N_SLAVES_V);

  // Routing is fixed by the latched select while a transfer is pending.
  assign cur_sel_c = (state_q == ST_BUSY) ? sel_q : addr_sel_c;

  // Response of the currently routed slave.
  always_comb begin
    sel_resp_c = '0;
    for (int unsigned k = 0; k < N_SLAVES; k++) begin
      if (cur_sel_c == NB'(k)) begin
        sel_resp_c = bus_io.s_resp[k*RESP_W +: RESP_W];
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    route_en_c = 1'b0;
    m_resp_c   = '0;
    case (state_q)
      ST_IDLE: begin
        if (m_valid_c) begin
          if (in_range_c) begin
            route_en_c = 1'b1;
            sel_d      = addr_sel_c;
            m_resp_c   = sel_resp_c;
            if (!sel_resp_c[0]) begin
              state_d = ST_BUSY;
            end
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_BUSY: begin
        // Keep forwarding even if valid drops; only ready ends the transfer.
        route_en_c = 1'b1;
        if (sel_resp_c[0]) begin
          m_resp_c = sel_resp_c;
          state_d  = ST_IDLE;
        end
      end
      ST_ERR: begin
        m_resp_c = RESP_W'(1);
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request fan-out; gated by rst_n so nothing leaks while in reset.
  for (genvar k = 0; k < N_SLAVES; k++) begin : g_slot
    assign bus_io.s_req[k*REQ_W +: REQ_W] =
      (rst_n && route_en_c && (cur_sel_c == NB'(k))) ? bus_io.m_req : '0;
  end

  assign bus_io.m_resp = rst_n ? m_resp_c : '0;

  // State and latched select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

endmodule

// File: tb/tb_iob_split.sv
// Scoreboard bench for iob_split with three slaves (select = addr[31:30],
// select 3 is out of range). Stimulus acts as master and as all slaves;
// expected responses are queued at issue time with the cycle they are due,
// and a negedge monitor checks routing and responses every cycle.
module tb_iob_split;
  localparam int unsigned NS     = 3;
  localparam int unsigned DW     = 32;
  localparam int unsigned AW     = 32;
  localparam int unsigned REQ_W  = 1 + AW + DW + DW / 8;
  localparam int unsigned RESP_W = DW + 1;

  typedef struct {
    logic [DW-1:0] rdata;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  iob_split_if #(.N_SLAVES(NS), .DATA_W(DW), .ADDR_W(AW)) bus ();

  iob_split #(
    .N_SLAVES(NS),
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .P_SLAVES(31)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus)
  );

  exp_t sb_q[$];
  int   cyc       = 0;
  int   exp_route = -1;
  int   total     = 0;
  int   bad       = 0;
  bit   done      = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: routing every cycle, responses against the scoreboard.
  always @(negedge clk) begin : mon
    logic [NS*REQ_W-1:0] exp_sreq;
    exp_t e;
    if (!done) begin
      exp_sreq = '0;
      if (exp_route >= 0) exp_sreq[exp_route*REQ_W +: REQ_W] = bus.m_req;
      total++;
      if (bus.s_req !== exp_sreq) begin
        bad++;
        $display("FAIL s_req cyc=%0d got=%h want=%h", cyc, bus.s_req, exp_sreq);
      end
      if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        e = sb_q.pop_front();
        total++;
        bad++;
        $display("FAIL missing_ready cyc=%0d got=none want=ready@%0d", cyc, e.cyc);
      end
      if (bus.m_resp[0] === 1'b1) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_ready cyc=%0d got=%h want=none", cyc, bus.m_resp);
        end else begin
          e = sb_q.pop_front();
          if (bus.m_resp[RESP_W-1:1] !== e.rdata || cyc != e.cyc) begin
            bad++;
            $display("FAIL resp cyc=%0d got=%h@%0d want=%h@%0d",
                     cyc, bus.m_resp[RESP_W-1:1], cyc, e.rdata, e.cyc);
          end
        end
      end else begin
        total++;
        if (bus.m_resp !== '0) begin
          bad++;
          $display("FAIL resp_idle cyc=%0d got=%h want=0", cyc, bus.m_resp);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW/8-1:0] s);
    bus.m_req = {v, a, d, s};
  endtask

  task automatic set_resp(input int k, input logic [DW-1:0] rd, input bit rdy);
    bus.s_resp[k*RESP_W +: RESP_W] = {rd, rdy};
  endtask

  // Random responses on every slave except excl (which the caller drives).
  task automatic noise(input int excl, input bit force_rdy);
    for (int k = 0; k < NS; k++) begin
      if (k != excl) set_resp(k, $urandom, force_rdy || ($urandom_range(0, 2) == 0));
    end
  endtask

  task automatic idle_cycle();
    set_req(1'b0, '0, '0, '0);
    exp_route = -1;
    noise(-1, 1'b0);
  endtask

  // One master transfer; the target answers after lat wait cycles.
  task automatic do_txn(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW/8-1:0] s, input logic [DW-1:0] rd,
                        input int lat, input bit viol, input bit addr_chg,
                        input bit iso);
    int t;
    int c0;
    logic [AW-1:0] a2;
    t  = int'(a[31:30]);
    c0 = cyc;
    set_req(1'b1, a, d, s);
    if (t >= NS) begin
      exp_route = -1;
      noise(-1, iso);
      sb_q.push_back('{rdata: '0, cyc: c0 + 1});
      next_cycle();
      noise(-1, iso);
    end else begin
      exp_route = t;
      noise(t, iso);
      if (lat == 0) set_resp(t, rd, 1'b1);
      else          set_resp(t, '0, 1'b0);
      sb_q.push_back('{rdata: rd, cyc: c0 + lat});
      for (int i = 1; i <= lat; i++) begin
        next_cycle();
        noise(t, iso);
        a2 = a;
        if (addr_chg) a2[31:30] = 2'($urandom);
        set_req(!viol, a2, d, s);
        if (i == lat) set_resp(t, rd, 1'b1);
        else          set_resp(t, $urandom, 1'b0);
      end
    end
  endtask

  initial begin
    // Reset with a pending request and a ready slave: everything must stay 0.
    rst_n    = 1'b0;
    bus.s_resp = '0;
    set_req(1'b1, 32'h4000_0000, 32'h1, 4'hF);
    set_resp(1, 32'h5555_AAAA, 1'b1);
    exp_route = -1;
    repeat (3) next_cycle();
    rst_n = 1'b1;
    idle_cycle();

    next_cycle(); do_txn(32'h8000_0010, $urandom, 4'hF, 32'hCAFE_BABE, 0, 0, 0, 0);
    next_cycle(); do_txn(32'h0000_0004, 32'h1234_5678, 4'hF, 32'h600D_0001, 3, 0, 0, 0);
    next_cycle(); idle_cycle();
    next_cycle(); do_txn(32'h0000_0100, $urandom, 4'h3, 32'h0000_0001, 2, 0, 0, 1);
    next_cycle(); do_txn(32'hC000_0000, $urandom, 4'hF, 32'h0, 0, 0, 0, 1);
    next_cycle(); do_txn(32'h4000_0008, $urandom, 4'hC, 32'h0000_0077, 3, 1, 1, 0);

    // Reset while a transfer to slave 1 is pending.
    next_cycle();
    set_req(1'b1, 32'h4000_0020, 32'hA5A5_A5A5, 4'hF);
    exp_route = 1;
    noise(1, 1'b0);
    set_resp(1, '0, 1'b0);
    next_cycle();
    noise(1, 1'b0);
    set_resp(1, $urandom, 1'b0);
    next_cycle();
    rst_n     = 1'b0;
    exp_route = -1;
    set_resp(1, 32'h0000_BAD0, 1'b1);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    idle_cycle();
    set_resp(1, 32'h0000_BEEF, 1'b1);  // late ready must be ignored
    next_cycle(); idle_cycle();

    // Random traffic.
    repeat (400) begin
      next_cycle();
      if ($urandom_range(0, 3) == 0) begin
        idle_cycle();
      end else begin
        do_txn($urandom, $urandom, 4'($urandom), $urandom,
               int'($urandom_range(0, 4)),
               $urandom_range(0, 7) == 0,
               $urandom_range(0, 3) == 0,
               $urandom_range(0, 7) == 0);
      end
    end

    next_cycle(); idle_cycle();
    repeat (3) next_cycle();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL leftover got=%0d want=0", sb_q.size());
    end
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
